// File: rtl/ex_div.sv
// Iterative radix-2 RV64M divider for the EX stage (DIV/DIVU/REM/REMU and W forms).
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module ex_div #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [4:0]      reg_waddr_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] result_o,
   output logic            ready_o,
   output logic            reg_we_o,
   output logic [4:0]      reg_waddr_o,
   output logic            busy_o,
   output logic            hold_req_o,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        op_q;
   logic              word_q;
   logic [4:0]        waddr_q;
   logic              q_neg_q, r_neg_q;
   logic [XLEN-1:0]   dvd_q, rem_q, dvs_q, result_q;

   logic              is_signed, a_neg, b_neg, div_zero, ovf, early, accept;
   logic [XLEN-1:0]   opa, opb, abs_a, abs_b;
   logic [XLEN:0]     rem_sh, rem_diff;
   logic              ge;
   logic [XLEN-1:0]   q_fin, r_fin, res_raw, res_fin;

   // Operand conditioning: W ops use the low word, extended by signedness.
   always_comb begin
      is_signed = ~op_i[0];
      opa       = dividend_i;
      opb       = divisor_i;
      if (word_i) begin
         opa = {{(XLEN-32){is_signed & dividend_i[31]}}, dividend_i[31:0]};
         opb = {{(XLEN-32){is_signed & divisor_i[31]}}, divisor_i[31:0]};
      end
      a_neg    = is_signed & opa[XLEN-1];
      b_neg    = is_signed & opb[XLEN-1];
      abs_a    = a_neg ? -opa : opa;
      abs_b    = b_neg ? -opb : opb;
      div_zero = (opb == '0);
      ovf      = is_signed & (&opb) &
                 (word_i ? (opa[31:0] == 32'h8000_0000) : (opa == {1'b1, {(XLEN-1){1'b0}}}));
`ifdef DIV_EARLY_OUT_EN
      early    = (abs_a < abs_b);
`else
      early    = 1'b0;
`endif
   end

   // One restoring shift-subtract step; quotient bits enter dvd_q from the bottom.
   always_comb begin
      rem_sh   = {rem_q, dvd_q[XLEN-1]};
      ge       = (rem_sh >= {1'b0, dvs_q});
      rem_diff = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
   end

   always_comb begin
      q_fin   = q_neg_q ? -dvd_q : dvd_q;
      r_fin   = r_neg_q ? -rem_q : rem_q;
      res_raw = op_q[1] ? r_fin : q_fin;
      res_fin = word_q ? {{(XLEN-32){res_raw[31]}}, res_raw[31:0]} : res_raw;
   end

   // Handshake: a request is taken when start_i=1 and flush_i=0 in IDLE; hold_req_o
   // stalls the pipe until the one-cycle ready_o/reg_we_o pulse carries result_o.
   always_comb begin
      state_d = state_q;
      accept  = (state_q == IDLE) & start_i & ~flush_i;
      case (state_q)
         IDLE: if (accept) state_d = (div_zero | ovf | early) ? DONE : CALC;
         CALC: if (flush_i) state_d = IDLE;
               else if (cnt_q == CNT_W'(1)) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_o     = (state_q == DONE);
      reg_we_o    = ready_o;
      busy_o      = (state_q != IDLE);
      hold_req_o  = accept | (state_q == CALC);
      result_o    = ready_o ? res_fin : result_q;
      reg_waddr_o = waddr_q;
      dbg_state   = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         waddr_q  <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         dvd_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op_i;
            word_q  <= word_i;
            waddr_q <= reg_waddr_i;
            dvs_q   <= abs_b;
            cnt_q   <= word_i ? CNT_W'(32) : CNT_W'(XLEN);
            // Special cases preload final values with no sign correction.
            if (div_zero) begin
               dvd_q   <= '1;
               rem_q   <= opa;
               q_neg_q <= 1'b0;
               r_neg_q <= 1'b0;
            end else if (ovf) begin
               dvd_q   <= opa;
               rem_q   <= '0;
               q_neg_q <= 1'b0;
               r_neg_q <= 1'b0;
            end else if (early) begin
               dvd_q   <= '0;
               rem_q   <= opa;
               q_neg_q <= 1'b0;
               r_neg_q <= 1'b0;
            end else begin
               dvd_q   <= word_i ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
               rem_q   <= '0;
               q_neg_q <= a_neg ^ b_neg;
               r_neg_q <= a_neg;
            end
         end else if ((state_q == CALC) && !flush_i) begin
            rem_q <= rem_diff[XLEN-1:0];
            dvd_q <= {dvd_q[XLEN-2:0], ge};
            cnt_q <= cnt_q - 1'b1;
         end
         if (ready_o) result_q <= res_fin;
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// Testbench for ex_div: vector table, random ops against a reference model, and
// hand-written flush/reset sequences, with a scoreboard on the ready_o pulse.
module tb_ex_div;

   logic        clk, rst_n, start_i, word_i, flush_i;
   logic [1:0]  op_i;
   logic [63:0] dividend_i, divisor_i, result_o;
   logic [4:0]  reg_waddr_i, reg_waddr_o;
   logic        ready_o, reg_we_o, busy_o, hold_req_o;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   logic [4:0]  exp_waddr_q[$];

`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_EO64 = 1;
`else
   localparam int LAT_EO64 = 65;
`endif

   typedef struct {
      logic [1:0]  op;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  waddr;
      logic [63:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs [0:15];

   ex_div dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .word_i(word_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
      .flush_i(flush_i), .result_o(result_o), .ready_o(ready_o), .reg_we_o(reg_we_o),
      .reg_waddr_o(reg_waddr_o), .busy_o(busy_o), .hold_req_o(hold_req_o),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 1000000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: every ready_o pulse must match the oldest pending op
   logic [63:0] sb_e;
   logic [4:0]  sb_w;
   always @(negedge clk) begin
      if (ready_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_ready: got ready_o=1 expected no pending op");
         end else begin
            sb_e = exp_q.pop_front();
            sb_w = exp_waddr_q.pop_front();
            check("result", result_o, sb_e);
            check("waddr", 64'(reg_waddr_o), 64'(sb_w));
            check("reg_we", 64'(reg_we_o), 64'd1);
         end
      end
   end

   // reference model
   function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, r32;
      logic [63:0] r64;
      logic sgn, rem;
      a32 = a[31:0];
      b32 = b[31:0];
      sgn = !op[0];
      rem = op[1];
      if (w) begin
         if (b32 == 32'h0) r32 = rem ? a32 : 32'hFFFF_FFFF;
         else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'h0 : a32;
         else if (sgn) r32 = rem ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
         else r32 = rem ? (a32 % b32) : (a32 / b32);
         return {{32{r32[31]}}, r32};
      end
      if (b == 64'h0) r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = rem ? 64'h0 : a;
      else if (sgn) r64 = rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
      else r64 = rem ? (a % b) : (a / b);
      return r64;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] ma, mb;
      logic sgn;
      sgn = !op[0];
      if (w) begin
         if (b[31:0] == 32'h0) return 1;
         if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
         ma = (sgn && a[31]) ? 64'(33'h1_0000_0000 - {1'b0, a[31:0]}) : {32'h0, a[31:0]};
         mb = (sgn && b[31]) ? 64'(33'h1_0000_0000 - {1'b0, b[31:0]}) : {32'h0, b[31:0]};
      end else begin
         if (b == 64'h0) return 1;
         if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
         ma = (sgn && a[63]) ? (64'h0 - a) : a;
         mb = (sgn && b[63]) ? (64'h0 - b) : b;
      end
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 1;
`endif
      return w ? 33 : 65;
   endfunction

   // driver: issue one op, measure latency, check the stall/busy profile
   task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] wa,
                         input logic [63:0] exp_res, input int exp_lat, input string name);
      int lat;
      bit got, hold_ok;
      @(negedge clk);
      op_i = op; word_i = w; dividend_i = a; divisor_i = b; reg_waddr_i = wa; start_i = 1'b1;
      exp_q.push_back(exp_res);
      exp_waddr_q.push_back(wa);
      #1 check({name, "_hold_start"}, 64'(hold_req_o), 64'd1);
      lat = 0; got = 0; hold_ok = 1;
      while (!got && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start_i = 1'b0;
         if (ready_o === 1'b1) begin
            got = 1;
            check({name, "_hold_done"}, 64'(hold_req_o), 64'd0);
            check({name, "_busy_done"}, 64'(busy_o), 64'd1);
         end else if (hold_req_o !== 1'b1 || busy_o !== 1'b1) begin
            hold_ok = 0;
         end
      end
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      if (exp_lat > 1) check({name, "_hold_calc"}, 64'(hold_ok), 64'd1);
   endtask

   logic [1:0]  r_op;
   logic        r_w;
   logic [63:0] r_a, r_b;

   initial begin
      vecs[0]  = '{2'b01, 1'b0, 64'd100, 64'd7, 5'd1, 64'd14, 65};
      vecs[1]  = '{2'b11, 1'b0, 64'd100, 64'd7, 5'd2, 64'd2, 65};
      vecs[2]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65};
      vecs[3]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 65};
      vecs[4]  = '{2'b01, 1'b0, 64'd5, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[5]  = '{2'b10, 1'b0, 64'd5, 64'd0, 5'd6, 64'd5, 1};
      vecs[6]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'h8000_0000_0000_0000, 1};
      vecs[7]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'h0, 1};
      vecs[8]  = '{2'b01, 1'b1, 64'h1_8000_0000, 64'd1, 5'd9, 64'hFFFF_FFFF_8000_0000, 33};
      vecs[9]  = '{2'b01, 1'b0, 64'd3, 64'd10, 5'd10, 64'd0, LAT_EO64};
      vecs[10] = '{2'b10, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 33};
      vecs[11] = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd12, 64'hFFFF_FFFF_8000_0000, 1};
      vecs[12] = '{2'b00, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD, 65};
      vecs[13] = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, LAT_EO64};
      vecs[14] = '{2'b11, 1'b1, 64'h0000_0000_8000_0009, 64'hFFFF_FFFF_0000_0000, 5'd15, 64'hFFFF_FFFF_8000_0009, 1};
      vecs[15] = '{2'b00, 1'b1, 64'd100, 64'h0000_0000_FFFF_FFF9, 5'd16, 64'hFFFF_FFFF_FFFF_FFF2, 33};

      rst_n = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; word_i = 1'b0;
      dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;
      repeat (3) @(negedge clk);
      check("rst_result", result_o, 64'h0);
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_hold", 64'(hold_req_o), 64'd0);
      check("rst_waddr", 64'(reg_waddr_o), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      rst_n = 1'b0;

      for (int i = 0; i < 16; i++)
         run_op(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].waddr,
                vecs[i].exp_res, vecs[i].exp_lat, $sformatf("vec%0d", i));

      for (int i = 0; i < 16; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_w  = 1'($urandom_range(0, 1));
         r_a  = {$urandom, $urandom};
         r_b  = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: r_b = r_b >> $urandom_range(1, 62);
            1: r_a = r_a >> $urandom_range(1, 62);
            2: r_b = $urandom_range(0, 1) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
            3: begin
               r_a = r_w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
               r_b = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            default: ;
         endcase
         run_op(r_op, r_w, r_a, r_b, 5'(i + 17), ref_res(r_op, r_w, r_a, r_b),
                ref_lat(r_op, r_w, r_a, r_b), $sformatf("rand%0d", i));
      end

      // flush mid-CALC at cycle 20, restart at cycle 22
      @(negedge clk);
      op_i = 2'b01; word_i = 1'b0; dividend_i = 64'd100; divisor_i = 64'd7;
      reg_waddr_i = 5'd5; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (19) @(negedge clk);
      check("flush_busy_before", 64'(busy_o), 64'd1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_busy_after", 64'(busy_o), 64'd0);
      run_op(2'b01, 1'b0, 64'd9, 64'd3, 5'd9, 64'd3, 65, "flush_next");

      // flush while in DONE: result still delivered
      @(negedge clk);
      op_i = 2'b01; word_i = 1'b0; dividend_i = 64'd5; divisor_i = 64'd0;
      reg_waddr_i = 5'd12; start_i = 1'b1;
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      exp_waddr_q.push_back(5'd12);
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b1;
      check("flush_done_ready", 64'(ready_o), 64'd1);
      @(negedge clk);
      flush_i = 1'b0;
      check("flush_done_busy", 64'(busy_o), 64'd0);

      // start together with flush in IDLE is refused
      @(negedge clk);
      op_i = 2'b01; dividend_i = 64'd100; divisor_i = 64'd7; reg_waddr_i = 5'd3;
      start_i = 1'b1; flush_i = 1'b1;
      #1 check("startflush_hold", 64'(hold_req_o), 64'd0);
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      check("startflush_busy", 64'(busy_o), 64'd0);

      // reset in the middle of CALC
      @(negedge clk);
      op_i = 2'b01; dividend_i = 64'd100; divisor_i = 64'd7; reg_waddr_i = 5'd7; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (8) @(negedge clk);
      check("midrst_busy_before", 64'(busy_o), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      check("midrst_result", result_o, 64'h0);
      check("midrst_waddr", 64'(reg_waddr_o), 64'd0);
      check("midrst_busy", 64'(busy_o), 64'd0);
      check("midrst_ready", 64'(ready_o), 64'd0);
      check("midrst_hold", 64'(hold_req_o), 64'd0);
      run_op(2'b11, 1'b0, 64'd100, 64'd7, 5'd30, 64'd2, 65, "post_rst");

      repeat (2) @(negedge clk);
      check("drain", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
